// File: rtl/alu_mc_if.sv
// ALU_MC request/result handshake bundle.
// master: drives IN_VALID/A/B/ALUOP/OUT_READY; slave (alu_mc): drives IN_READY/OUT_VALID/ALURES/ZERO/ERR.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUOP;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] ALURES;
  logic             ZERO;
  logic             ERR;

  modport master (
    output IN_VALID, A, B, ALUOP, OUT_READY,
    input  IN_READY, OUT_VALID, ALURES, ZERO, ERR
  );

  modport slave (
    input  IN_VALID, A, B, ALUOP, OUT_READY,
    output IN_READY, OUT_VALID, ALURES, ZERO, ERR
  );
endinterface

// File: rtl/alu_mc.sv
// ALU_MC: valid/ready ALU, 1-cycle ops, optional WIDTH-cycle shift-add MUL.
// Ports: CLK, RST_N (sync, active-low), bus (alu_mc_if.slave). Macro: ALU_MC_MUL_EN.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input logic     CLK,
  input logic     RST_N,
  alu_mc_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic             is_mul;
  logic             in_ready;
  logic             accept;
  logic [SHW-1:0]   shamt;

  assign shamt  = bus.B[SHW-1:0];
  assign accept = bus.IN_VALID && in_ready;

`ifdef ALU_MC_MUL_EN
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_nxt;
  logic             mul_last;

  assign acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (cnt_q == SHW'(WIDTH - 1));
`endif

  always_comb begin : alu
    alu_res = '0;
    alu_err = 1'b0;
    is_mul  = 1'b0;
    case (bus.ALUOP)
      4'b0000: alu_res = bus.A + bus.B;
      4'b1000: alu_res = bus.A - bus.B;
      4'b0001: alu_res = bus.A << shamt;
      4'b0010: alu_res = {{(WIDTH-1){1'b0}},
                          $signed(bus.A) < $signed(bus.B)};
      4'b0011: alu_res = {{(WIDTH-1){1'b0}},
                          bus.A < bus.B};
      4'b0100: alu_res = bus.A ^ bus.B;
      4'b0101: alu_res = bus.A >> shamt;
      4'b1101: alu_res = $signed(bus.A) >>> shamt;
      4'b0110: alu_res = bus.A | bus.B;
      4'b0111: alu_res = bus.A & bus.B;
`ifdef ALU_MC_MUL_EN
      4'b1001: is_mul = 1'b1;
`endif
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      res_q    <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_MC_MUL_EN
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
`ifdef ALU_MC_MUL_EN
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = is_mul ? BUSY : DONE;
          if (!is_mul) begin
            res_d  = alu_res;
            zero_d = (alu_res == '0);
            err_d  = alu_err;
          end
        end else if (state_q == DONE && bus.OUT_READY) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
`ifdef ALU_MC_MUL_EN
        if (mul_last) begin
          state_d = DONE;
          res_d   = acc_nxt;
          zero_d  = (acc_nxt == '0);
          err_d   = 1'b0;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_MC_MUL_EN
  // One multiplier bit per BUSY cycle, LSB first.
  always_comb begin : mul_step
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (accept && is_mul) begin
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = bus.A;
      mplier_d = bus.B;
    end else if (state_q == BUSY) begin
      cnt_d    = cnt_q + SHW'(1);
      acc_d    = acc_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end
`endif

  always_comb begin : outputs
    in_ready = (state_q == IDLE) ||
               (state_q == DONE && bus.OUT_READY);
    bus.IN_READY  = in_ready;
    bus.OUT_VALID = (state_q == DONE);
    bus.ALURES    = res_q;
    bus.ZERO      = zero_q;
    bus.ERR       = err_q;
  end
endmodule
